zion_riscv_isa_lib_add_sub_ex_stage: RTL
========================================

Name: zion_riscv_isa_lib_add_sub_ex_stage

Overview:
- Execute-stage pipeline register for the ADD/SUB/ADDW/SUBW and less-than (BLT[U]/BGE[U]/SLT[I][U]) datapath.
- Sits between the decode stage, which supplies op/s1/s2, and writeback/branch resolution.
- Accepts one operation per cycle over valid/ready and computes sum/difference and less-than flag.
- Presents registered results downstream, with a one-entry skid so upstream ready is a pure register output.

Parameters:
RV64, 0, 1 = RV64I datapath (64-bit, .W ops legal); 0 = RV32I (32-bit).
TAG_W, 5, width of the destination tag carried alongside each operation (rd index).

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
iValid  input  1  decode presents an operation.
oReady  output  1  stage can accept; registered, equals ~skidVld.
iOp  input  RV64+2  op[0]=add, op[1]=sub, op[2]=.W (present only when RV64=1).
iUnsigned  input  1  less-than is unsigned (BLTU/BGEU/SLTU).
iS1  input  32*(RV64+1)  source operand 1.
iS2  input  32*(RV64+1)  source operand 2.
iTag  input  TAG_W  destination tag.
oValid  output  1  result register holds a valid entry.
iReady  input  1  downstream accepts.
oRslt  output  32*(RV64+1)  add/sub result.
oLessThan  output  1  s1<s2 (meaningful only for sub ops).
oTag  output  TAG_W  tag of oRslt.
oOpErr  output  1  sticky illegal-op flag.

Behaviour:
- Reset (rst_n=0, async): oValid=0, skidVld=0, oReady=1, oRslt=0, oLessThan=0, oTag=0, oOpErr=0. Reset mid-operation drops all in-flight entries; no partial outputs.
- Accept: acc = iValid & oReady. Compute is combinational on the input side; the result is captured on the acc edge. Latency is 1 cycle from acc to oValid when the output register is free.
- Arithmetic:
  - add: s1+s2.
  - sub: s1+~s2+1.
  - Width is 32*(RV64+1); carry-out is discarded (wrap-around).
  - When RV64=1 and op[2]=1, rslt = sign-extend(raw[31:0]) to 64 bits.
- LessThan, using msb of s1, s2 and the raw difference:
  - Signs differ: lt = iUnsigned ? s2msb : s1msb.
  - Signs equal: lt = diff msb.
  - Overflow-correct in both signed and unsigned modes.
  - With op[2]=1, the 32-bit msbs (bit 31) are used.
- Illegal op: op[0]&op[1], or op[0]|op[1]==0.
  - The entry is still accepted with rslt=0 and lt=0.
  - oOpErr is set and stays set until reset.
  - When RV64=0, there is no op[2].
- State machine (oValid, skidVld):
  - EMPTY (0,0):
    - acc -> ONE (load output register).
  - ONE (1,0):
    - acc & iReady -> ONE (output register overwritten with new entry).
    - acc & ~iReady -> FULL (new entry into skid).
    - ~acc & iReady -> EMPTY.
    - else hold.
  - FULL (1,1), oReady=0:
    - iReady -> ONE (skid moves into output register the same edge).
    - else hold.
- Output register and skid contents are held stable while oValid & ~iReady (AXI-style stability).
- Order is strictly preserved; no entry is ever dropped or duplicated.

Decomposition:
- Shared package zion_riscv_isa_lib_pkg holds:
  - op bit-index constants: OP_ADD=0, OP_SUB=1, OP_W=2.
  - state enum ex_stage_state_e {EMPTY, ONE, FULL}.
  - function add_sub_lt computing {rslt, lt} from op/s1/s2/unsigned.
- One sub-module, zion_riscv_isa_lib_ex_skid_buf: a generic 2-entry valid/ready register, parameterized by payload width. The top level packs {rslt, lt, tag} into the payload.

Test Plan:
- RV32: add s1=0xFFFF_FFFF, s2=1, iReady=1 -> next cycle oValid=1, oRslt=0 (wrap), oTag as driven.
- RV32: sub s1=0x8000_0000, s2=1, signed -> oRslt=0x7FFF_FFFF, oLessThan=1; same with iUnsigned=1 -> oLessThan=0.
- RV64: subw s1=0, s2=1 -> oRslt=0xFFFF_FFFF_FFFF_FFFF. addw s1=0x7FFF_FFFF, s2=1 -> oRslt=0xFFFF_FFFF_8000_0000.
- Backpressure:
  - Hold iReady=0 while streaming 3 ops A, B, C.
  - A lands in the output register, B in the skid, oReady=0 from the next cycle, C is stalled.
  - Raise iReady -> A, B, C delivered in order, none lost.
- Illegal op: op=2'b11 -> entry delivered with oRslt=0, oOpErr=1, and oOpErr remains 1 after later legal ops until rst_n low.
- Assert rst_n=0 asynchronously while in FULL -> oValid, oReady=1, oOpErr=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/zion_riscv_isa_lib_pkg.sv
// Shared definitions for the zion RISC-V ISA library execute stages:
// op bit positions, the ex-stage occupancy states and the add/sub/less-than kernel.
package zion_riscv_isa_lib_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_W   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ex_stage_state_e;

    function automatic logic opIllegal(input logic [2:0] op);
        return ~(op[OP_ADD] ^ op[OP_SUB]);
    endfunction

    // Operands arrive zero-extended to 64 bits; rv64=0 means only the low word is meaningful.
    // Returns {rslt[63:0], lt}.
    function automatic logic [64:0] add_sub_lt(
        input logic [2:0]  op,
        input logic [63:0] s1,
        input logic [63:0] s2,
        input logic        isUnsigned,
        input logic        rv64
    );
        logic [63:0] raw;
        logic [63:0] rslt;
        logic        narrow;
        logic        s1Msb;
        logic        s2Msb;
        logic        dMsb;
        logic        lt;

        raw    = op[OP_SUB] ? (s1 + ~s2 + 64'd1) : (s1 + s2);
        narrow = ~rv64 | op[OP_W];
        s1Msb  = narrow ? s1[31]  : s1[63];
        s2Msb  = narrow ? s2[31]  : s2[63];
        dMsb   = narrow ? raw[31] : raw[63];
        // When the signs differ the raw difference may have overflowed, so the answer comes from the operands.
        lt     = (s1Msb != s2Msb) ? (isUnsigned ? s2Msb : s1Msb) : dMsb;

        if (!rv64) begin
            rslt = {32'd0, raw[31:0]};
        end else if (op[OP_W]) begin
            rslt = {{32{raw[31]}}, raw[31:0]};
        end else begin
            rslt = raw;
        end

        if (opIllegal(op)) begin
            rslt = '0;
            lt   = 1'b0;
        end
        return {rslt, lt};
    endfunction

endpackage

// File: rtl/zion_riscv_isa_lib_ex_skid_buf.sv
// Two-entry valid/ready pipeline register: an output register backed by one skid entry,
// so the upstream ready is a pure flop output.
module zion_riscv_isa_lib_ex_skid_buf
    import zion_riscv_isa_lib_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         iValid,
    output logic         oReady,
    input  logic [W-1:0] iData,
    output logic         oValid,
    input  logic         iReady,
    output logic [W-1:0] oData
);

    ex_stage_state_e state;
    logic [W-1:0]    outReg;
    logic [W-1:0]    skidReg;
    logic            validReg;
    logic            readyReg;
    logic            acc;

    assign acc    = iValid & readyReg;
    assign oValid = validReg;
    assign oReady = readyReg;
    assign oData  = outReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            outReg   <= '0;
            skidReg  <= '0;
            validReg <= 1'b0;
            readyReg <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        outReg   <= iData;
                        validReg <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (acc && iReady) begin
                        outReg <= iData;
                    end else if (acc) begin
                        skidReg  <= iData;
                        readyReg <= 1'b0;
                        state    <= FULL;
                    end else if (iReady) begin
                        validReg <= 1'b0;
                        state    <= EMPTY;
                    end
                end
                FULL: begin
                    // Skid drains into the output register on the same edge the old head leaves.
                    if (iReady) begin
                        outReg   <= skidReg;
                        readyReg <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    validReg <= 1'b0;
                    readyReg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/zion_riscv_isa_lib_add_sub_ex_stage.sv
// Execute stage for ADD/SUB(W) and the less-than compare, registered through a skid buffer.
module zion_riscv_isa_lib_add_sub_ex_stage
    import zion_riscv_isa_lib_pkg::*;
#(
    parameter int RV64  = 0,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [RV64+1:0]          iOp,
    input  logic                     iUnsigned,
    input  logic [32*(RV64+1)-1:0]   iS1,
    input  logic [32*(RV64+1)-1:0]   iS2,
    input  logic [TAG_W-1:0]         iTag,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [32*(RV64+1)-1:0]   oRslt,
    output logic                     oLessThan,
    output logic [TAG_W-1:0]         oTag,
    output logic                     oOpErr
);

    localparam int XLEN = 32 * (RV64 + 1);
    localparam int PW   = XLEN + 1 + TAG_W;

    logic [2:0]    opExt;
    logic [63:0]   s1Ext;
    logic [63:0]   s2Ext;
    logic [64:0]   calc;
    logic [PW-1:0] payloadIn;
    logic [PW-1:0] payloadOut;
    logic          acc;

    // RV32 has no .W bit, so it reads as zero after extension.
    assign opExt     = 3'(iOp);
    assign s1Ext     = 64'(iS1);
    assign s2Ext     = 64'(iS2);
    assign calc      = add_sub_lt(opExt, s1Ext, s2Ext, iUnsigned, RV64 != 0);
    assign payloadIn = {calc[XLEN:1], calc[0], iTag};
    assign acc       = iValid & oReady;

    zion_riscv_isa_lib_ex_skid_buf #(
        .W (PW)
    ) uSkid (
        .clk    (clk),
        .rst_n  (rst_n),
        .iValid (iValid),
        .oReady (oReady),
        .iData  (payloadIn),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (payloadOut)
    );

    assign {oRslt, oLessThan, oTag} = payloadOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oOpErr <= 1'b0;
        end else if (acc && opIllegal(opExt)) begin
            oOpErr <= 1'b1;
        end
    end

endmodule
